// File: rtl/audio_uart_framer.sv
// Audio UART framer: buffers 24-bit samples truncated to 16 bits and emits
// SYNC / SEQ / {hi,lo}xN / CSUM byte frames to a single-byte transmitter.
module audio_uart_framer #(
  parameter int unsigned SAMPLE_WIDTH      = 24,
  parameter int unsigned FIFO_DEPTH        = 16,
  parameter int unsigned SAMPLES_PER_FRAME = 8,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [SAMPLE_WIDTH-1:0]     sample_in,
  input  logic                        sample_valid_in,
  input  logic                        enable_in,
  input  logic                        tx_busy_in,
  output logic [7:0]                  byte_out,
  output logic                        byte_trigger_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_out,
  output logic [15:0]                 overflow_count_out,
  output logic [7:0]                  frame_count_out
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(SAMPLES_PER_FRAME) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_HI,
    ST_LO,
    ST_CSUM,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             guard_q, guard_d;
  logic [7:0]       byte_q, byte_d;
  logic             trig_q, trig_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       frame_q, frame_d;
  logic [7:0]       hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]      ovf_q, ovf_d;
  logic [15:0]      mem_q [FIFO_DEPTH];

  logic [15:0] word_c;
  logic [15:0] head_c;
  logic        accept_c, push_c, pop_c, ready_c;
  logic        unused_low_c;

  assign word_c = sample_in[SAMPLE_WIDTH-1 -: 16];
  assign head_c = mem_q[rd_ptr_q];

  // Truncated LSBs are intentionally discarded.
  if (SAMPLE_WIDTH > 16) begin : g_low
    assign unused_low_c = ^sample_in[SAMPLE_WIDTH-17:0];
  end else begin : g_nolow
    assign unused_low_c = 1'b0;
  end

  // FIFO bookkeeping; a same-cycle pop frees room for a push into a full FIFO.
  always_comb begin
    accept_c = sample_valid_in && enable_in;
    push_c   = accept_c && ((level_q < LVL_W'(FIFO_DEPTH)) || pop_c);
    level_d  = level_q;
    if (push_c && !pop_c) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_c && pop_c) begin
      level_d = level_q - LVL_W'(1);
    end
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    ovf_d    = ovf_q;
    if (accept_c && !push_c && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  // Frame sequencer: each trigger is followed by one guard cycle, then waits for busy low.
  always_comb begin
    state_d = state_q;
    guard_d = 1'b0;
    byte_d  = byte_q;
    trig_d  = 1'b0;
    csum_d  = csum_q;
    seq_d   = seq_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    pop_c   = 1'b0;
    ready_c = !guard_q && !tx_busy_in;
    case (state_q)
      ST_IDLE: begin
        if (level_q >= LVL_W'(SAMPLES_PER_FRAME)) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (ready_c) begin
          byte_d  = SYNC_BYTE;
          trig_d  = 1'b1;
          guard_d = 1'b1;
          csum_d  = 8'h00;
          state_d = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (ready_c) begin
          byte_d  = seq_q;
          trig_d  = 1'b1;
          guard_d = 1'b1;
          csum_d  = csum_q ^ seq_q;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (ready_c) begin
          pop_c   = 1'b1;
          hold_d  = head_c[7:0];
          byte_d  = head_c[15:8];
          trig_d  = 1'b1;
          guard_d = 1'b1;
          csum_d  = csum_q ^ head_c[15:8];
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (ready_c) begin
          byte_d  = hold_q;
          trig_d  = 1'b1;
          guard_d = 1'b1;
          csum_d  = csum_q ^ hold_q;
          idx_d   = idx_q + IDX_W'(1);
          state_d = (idx_q == IDX_W'(SAMPLES_PER_FRAME - 1)) ? ST_CSUM : ST_HI;
        end
      end
      ST_CSUM: begin
        if (ready_c) begin
          byte_d  = csum_q;
          trig_d  = 1'b1;
          guard_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_c) begin
          seq_d   = seq_q + 8'd1;
          frame_d = frame_q + 8'd1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      guard_q  <= 1'b0;
      byte_q   <= 8'h00;
      trig_q   <= 1'b0;
      csum_q   <= 8'h00;
      seq_q    <= 8'h00;
      frame_q  <= 8'h00;
      hold_q   <= 8'h00;
      idx_q    <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      byte_q   <= byte_d;
      trig_q   <= trig_d;
      csum_q   <= csum_d;
      seq_q    <= seq_d;
      frame_q  <= frame_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage; contents are don't-care until the pointers make them valid.
  always_ff @(posedge clk_in) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= word_c;
    end
  end

  assign byte_out           = byte_q;
  assign byte_trigger_out   = trig_q;
  assign fifo_level_out     = level_q;
  assign overflow_count_out = ovf_q;
  assign frame_count_out    = frame_q;

endmodule

// File: tb/tb_audio_uart_framer.sv
// Bench for audio_uart_framer: random samples against a frame-level reference
// model, plus a transmitter model that holds busy for a configurable time.
`timescale 1ns/1ps
module tb_audio_uart_framer;
  localparam int unsigned N           = 8;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned FRAME_BYTES = 2 * N + 3;

  logic        clk_in          = 1'b0;
  logic        rst_in          = 1'b1;
  logic [23:0] sample_in       = '0;
  logic        sample_valid_in = 1'b0;
  logic        enable_in       = 1'b0;
  logic        tx_busy_in      = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_trigger_out;
  logic [4:0]  fifo_level_out;
  logic [15:0] overflow_count_out;
  logic [7:0]  frame_count_out;

  audio_uart_framer dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .sample_in          (sample_in),
    .sample_valid_in    (sample_valid_in),
    .enable_in          (enable_in),
    .tx_busy_in         (tx_busy_in),
    .byte_out           (byte_out),
    .byte_trigger_out   (byte_trigger_out),
    .fifo_level_out     (fifo_level_out),
    .overflow_count_out (overflow_count_out),
    .frame_count_out    (frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Transmitter model and byte monitor (only this block writes these).
  int         busy_len  = 0;
  bit         stall     = 1'b0;
  int         busy_left = 0;
  logic [7:0] rx_q[$];
  int         pops_seen = 0;
  int         pos       = 0;
  int         viol_busy = 0, viol_stable = 0, viol_space = 0;
  logic [7:0] last_byte = 8'h00;
  bit         last_trig = 1'b0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      pos       = 0;
      last_trig = 1'b0;
      last_byte = byte_out;
    end else begin
      if (byte_trigger_out) begin
        if (tx_busy_in) viol_busy++;
        if (last_trig) viol_space++;
        rx_q.push_back(byte_out);
        if (pos >= 2 && pos < 2 + 2 * N && (pos % 2) == 0) pops_seen++;
        pos       = (pos + 1) % FRAME_BYTES;
        last_byte = byte_out;
      end else if (byte_out !== last_byte) begin
        viol_stable++;
      end
      last_trig = byte_trigger_out;
    end
    if (byte_trigger_out && !rst_in) busy_left = busy_len;
    else if (busy_left > 0) busy_left--;
    tx_busy_in = stall || (busy_left > 0);
  end

  // Reference model: accepted words grouped into frames of N.
  logic [7:0]  exp_q[$];
  logic [15:0] word_q[$];
  int          rx_base      = 0;
  int          acc_cnt      = 0;
  int          pops_base    = 0;
  logic [7:0]  model_seq    = 8'h00;
  int          model_ovf    = 0;
  int          model_frames = 0;

  function automatic int model_level();
    return acc_cnt - (pops_seen - pops_base);
  endfunction

  function automatic void build_frame();
    logic [7:0] cs;
    cs = model_seq;
    exp_q.push_back(8'hA5);
    exp_q.push_back(model_seq);
    foreach (word_q[i]) begin
      exp_q.push_back(word_q[i][15:8]);
      exp_q.push_back(word_q[i][7:0]);
      cs = cs ^ word_q[i][15:8] ^ word_q[i][7:0];
    end
    exp_q.push_back(cs);
    word_q.delete();
    model_seq = model_seq + 8'd1;
    model_frames++;
  endfunction

  function automatic int first_diff();
    int n;
    n = (rx_q.size() - rx_base < exp_q.size()) ? rx_q.size() - rx_base : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (rx_q[rx_base + i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [23:0] s);
    sample_in       = s;
    sample_valid_in = 1'b1;
    if (enable_in) begin
      if (model_level() < DEPTH) begin
        acc_cnt++;
        word_q.push_back(s[23:8]);
        if (word_q.size() == N) build_frame();
      end else if (model_ovf < 16'hFFFF) begin
        model_ovf++;
      end
    end
    @(posedge clk_in);
    #1;
    sample_valid_in = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while ((rx_q.size() - rx_base) < n && k < budget) begin
      @(posedge clk_in);
      k++;
    end
    #1;
    ok = ((rx_q.size() - rx_base) >= n);
  endtask

  task automatic model_reset();
    exp_q.delete();
    word_q.delete();
    rx_base      = rx_q.size();
    acc_cnt      = 0;
    pops_base    = pops_seen;
    model_seq    = 8'h00;
    model_ovf    = 0;
    model_frames = 0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cycles(3);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    cycles(1);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (byte_out !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", byte_out); end
    total++; if (byte_trigger_out !== 1'b0) begin bad++; $display("FAIL reset_trig got=%b exp=0", byte_trigger_out); end
    total++; if (fifo_level_out !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level_out); end
    total++; if (overflow_count_out !== 16'd0) begin bad++; $display("FAIL reset_ovf got=%0d exp=0", overflow_count_out); end
    total++; if (frame_count_out !== 8'd0) begin bad++; $display("FAIL reset_frames got=%0d exp=0", frame_count_out); end
    enable_in = 1'b1;
  endtask

  task automatic test_single_frame();
    bit ok;
    int d;
    int vb, vs, vp;
    vb = viol_busy; vs = viol_stable; vp = viol_space;
    busy_len = 0;
    for (int i = 0; i < 8; i++) push(24'h123456 + 24'(i));
    total++; if (fifo_level_out !== 5'd8) begin bad++; $display("FAIL single_level_full got=%0d exp=8", fifo_level_out); end
    wait_rx(FRAME_BYTES, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d bytes exp=%0d", rx_q.size() - rx_base, FRAME_BYTES); end
    cycles(4);
    total++; if (rx_q.size() - rx_base != exp_q.size()) begin bad++; $display("FAIL single_len got=%0d exp=%0d", rx_q.size() - rx_base, exp_q.size()); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL single_stream idx=%0d got=%h exp=%h", d, rx_q[rx_base + d], exp_q[d]); end
    if (ok) begin
      total++; if (rx_q[rx_base + FRAME_BYTES - 1] !== 8'h00) begin bad++; $display("FAIL single_csum got=%h exp=00", rx_q[rx_base + FRAME_BYTES - 1]); end
      total++; if (rx_q[rx_base + 2] !== 8'h12 || rx_q[rx_base + 3] !== 8'h34) begin bad++; $display("FAIL single_trunc got=%h%h exp=1234", rx_q[rx_base + 2], rx_q[rx_base + 3]); end
    end
    total++; if (frame_count_out !== 8'd1) begin bad++; $display("FAIL single_frames got=%0d exp=1", frame_count_out); end
    total++; if (fifo_level_out !== 5'd0) begin bad++; $display("FAIL single_level_empty got=%0d exp=0", fifo_level_out); end
    total++; if (viol_busy != vb || viol_stable != vs || viol_space != vp) begin bad++; $display("FAIL single_handshake got=%0d/%0d/%0d exp=0/0/0", viol_busy - vb, viol_stable - vs, viol_space - vp); end
    rx_base = rx_q.size(); exp_q.delete();
  endtask

  task automatic test_partial_frame();
    bit ok, seen;
    int d;
    for (int i = 0; i < 7; i++) push(24'($urandom));
    cycles(40);
    total++; if (rx_q.size() != rx_base) begin bad++; $display("FAIL partial_no_trigger got=%0d bytes exp=0", rx_q.size() - rx_base); end
    total++; if (fifo_level_out !== 5'(model_level())) begin bad++; $display("FAIL partial_level got=%0d exp=%0d", fifo_level_out, model_level()); end
    push(24'($urandom));
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycles(1);
      if (byte_trigger_out) begin seen = 1'b1; break; end
    end
    total++; if (!seen || byte_out !== 8'hA5) begin bad++; $display("FAIL partial_start got=trig%b byte%h exp=trig1 byteA5", seen, byte_out); end
    wait_rx(FRAME_BYTES, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL partial_timeout got=%0d bytes exp=%0d", rx_q.size() - rx_base, FRAME_BYTES); end
    cycles(4);
    d = first_diff();
    total++; if (d >= 0 || rx_q.size() - rx_base != exp_q.size()) begin bad++; $display("FAIL partial_stream idx=%0d got_len=%0d exp_len=%0d", d, rx_q.size() - rx_base, exp_q.size()); end
    total++; if (frame_count_out !== 8'(model_frames)) begin bad++; $display("FAIL partial_frames got=%0d exp=%0d", frame_count_out, model_frames); end
    rx_base = rx_q.size(); exp_q.delete();
  endtask

  task automatic test_busy_handshake();
    bit ok;
    int d;
    int vb, vs, vp;
    vb = viol_busy; vs = viol_stable; vp = viol_space;
    busy_len = 100;
    for (int i = 0; i < 8; i++) push(24'($urandom));
    wait_rx(FRAME_BYTES, FRAME_BYTES * 110 + 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout got=%0d bytes exp=%0d", rx_q.size() - rx_base, FRAME_BYTES); end
    cycles(110);
    busy_len = 0;
    d = first_diff();
    total++; if (d >= 0 || rx_q.size() - rx_base != exp_q.size()) begin bad++; $display("FAIL busy_stream idx=%0d got_len=%0d exp_len=%0d", d, rx_q.size() - rx_base, exp_q.size()); end
    total++; if (viol_busy != vb) begin bad++; $display("FAIL busy_trigger_while_busy got=%0d exp=0", viol_busy - vb); end
    total++; if (viol_stable != vs) begin bad++; $display("FAIL busy_byte_unstable got=%0d exp=0", viol_stable - vs); end
    total++; if (viol_space != vp) begin bad++; $display("FAIL busy_spacing got=%0d exp=0", viol_space - vp); end
    total++; if (frame_count_out !== 8'(model_frames)) begin bad++; $display("FAIL busy_frames got=%0d exp=%0d", frame_count_out, model_frames); end
    rx_base = rx_q.size(); exp_q.delete();
  endtask

  task automatic test_enable_low();
    enable_in = 1'b0;
    for (int i = 0; i < 5; i++) push(24'($urandom));
    cycles(3);
    total++; if (fifo_level_out !== 5'(model_level())) begin bad++; $display("FAIL enable_level got=%0d exp=%0d", fifo_level_out, model_level()); end
    total++; if (overflow_count_out !== 16'(model_ovf)) begin bad++; $display("FAIL enable_ovf got=%0d exp=%0d", overflow_count_out, model_ovf); end
    total++; if (rx_q.size() != rx_base) begin bad++; $display("FAIL enable_no_trigger got=%0d bytes exp=0", rx_q.size() - rx_base); end
    enable_in = 1'b1;
  endtask

  task automatic test_overflow();
    bit ok;
    int d;
    stall = 1'b1;
    cycles(2);
    for (int i = 0; i < 20; i++) push(24'($urandom));
    cycles(5);
    total++; if (fifo_level_out !== 5'(model_level()) || model_level() != DEPTH) begin bad++; $display("FAIL ovf_level got=%0d exp=%0d", fifo_level_out, DEPTH); end
    total++; if (overflow_count_out !== 16'(model_ovf) || model_ovf != 4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", overflow_count_out); end
    total++; if (rx_q.size() != rx_base) begin bad++; $display("FAIL ovf_stalled got=%0d bytes exp=0", rx_q.size() - rx_base); end
    busy_len = int'($urandom_range(0, 3));
    stall = 1'b0;
    wait_rx(2 * FRAME_BYTES, 600, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_timeout got=%0d bytes exp=%0d", rx_q.size() - rx_base, 2 * FRAME_BYTES); end
    cycles(10);
    d = first_diff();
    total++; if (d >= 0 || rx_q.size() - rx_base != exp_q.size()) begin bad++; $display("FAIL ovf_stream idx=%0d got_len=%0d exp_len=%0d", d, rx_q.size() - rx_base, exp_q.size()); end
    total++; if (fifo_level_out !== 5'd0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", fifo_level_out); end
    total++; if (frame_count_out !== 8'(model_frames)) begin bad++; $display("FAIL ovf_frames got=%0d exp=%0d", frame_count_out, model_frames); end
    busy_len = 0;
    rx_base = rx_q.size(); exp_q.delete();
  endtask

  task automatic test_seq_wrap();
    bit ok;
    int d;
    do_reset();
    enable_in = 1'b1;
    busy_len  = 0;
    ok = 1'b1;
    for (int f = 0; f < 256 && ok; f++) begin
      for (int i = 0; i < 8; i++) push(24'($urandom));
      if (($urandom & 3) == 0) cycles(int'($urandom_range(1, 5)));
      if (f > 0) wait_rx(FRAME_BYTES * f, 300, ok);
    end
    if (ok) wait_rx(FRAME_BYTES * 256, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=%0d bytes exp=%0d", rx_q.size() - rx_base, FRAME_BYTES * 256); end
    cycles(6);
    total++; if (frame_count_out !== 8'd0) begin bad++; $display("FAIL wrap_frames got=%0d exp=0", frame_count_out); end
    if (ok) begin
      total++; if (rx_q[rx_base + FRAME_BYTES * 255 + 1] !== 8'hFF) begin bad++; $display("FAIL wrap_seq_ff got=%h exp=ff", rx_q[rx_base + FRAME_BYTES * 255 + 1]); end
    end
    for (int i = 0; i < 8; i++) push(24'($urandom));
    wait_rx(FRAME_BYTES * 257, 300, ok);
    cycles(6);
    if (ok) begin
      total++; if (rx_q[rx_base + FRAME_BYTES * 256 + 1] !== 8'h00) begin bad++; $display("FAIL wrap_seq_00 got=%h exp=00", rx_q[rx_base + FRAME_BYTES * 256 + 1]); end
    end
    total++; if (frame_count_out !== 8'd1) begin bad++; $display("FAIL wrap_frames_after got=%0d exp=1", frame_count_out); end
    d = first_diff();
    total++; if (d >= 0 || rx_q.size() - rx_base != exp_q.size()) begin bad++; $display("FAIL wrap_stream idx=%0d got_len=%0d exp_len=%0d", d, rx_q.size() - rx_base, exp_q.size()); end
    rx_base = rx_q.size(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    bit ok;
    int d;
    int vb, vs, vp;
    vb = viol_busy; vs = viol_stable; vp = viol_space;
    busy_len = 20;
    for (int i = 0; i < 8; i++) push(24'($urandom));
    wait_rx(5, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL areset_prefill got=%0d bytes exp=5", rx_q.size() - rx_base); end
    cycles(1);
    #2 rst_in = 1'b1;
    #1;
    total++; if (byte_out !== 8'h00) begin bad++; $display("FAIL areset_byte got=%h exp=00", byte_out); end
    total++; if (byte_trigger_out !== 1'b0) begin bad++; $display("FAIL areset_trig got=%b exp=0", byte_trigger_out); end
    total++; if (fifo_level_out !== 5'd0) begin bad++; $display("FAIL areset_level got=%0d exp=0", fifo_level_out); end
    total++; if (overflow_count_out !== 16'd0) begin bad++; $display("FAIL areset_ovf got=%0d exp=0", overflow_count_out); end
    total++; if (frame_count_out !== 8'd0) begin bad++; $display("FAIL areset_frames got=%0d exp=0", frame_count_out); end
    cycles(2);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    busy_len = 0;
    cycles(25);
    for (int i = 0; i < 8; i++) push(24'($urandom));
    wait_rx(FRAME_BYTES, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL areset_timeout got=%0d bytes exp=%0d", rx_q.size() - rx_base, FRAME_BYTES); end
    cycles(6);
    if (ok) begin
      total++; if (rx_q[rx_base] !== 8'hA5 || rx_q[rx_base + 1] !== 8'h00) begin bad++; $display("FAIL areset_head got=%h,%h exp=a5,00", rx_q[rx_base], rx_q[rx_base + 1]); end
    end
    d = first_diff();
    total++; if (d >= 0 || rx_q.size() - rx_base != exp_q.size()) begin bad++; $display("FAIL areset_stream idx=%0d got_len=%0d exp_len=%0d", d, rx_q.size() - rx_base, exp_q.size()); end
    total++; if (frame_count_out !== 8'd1) begin bad++; $display("FAIL areset_frames_after got=%0d exp=1", frame_count_out); end
    total++; if (viol_busy != vb || viol_stable != vs || viol_space != vp) begin bad++; $display("FAIL areset_handshake got=%0d/%0d/%0d exp=0/0/0", viol_busy - vb, viol_stable - vs, viol_space - vp); end
    rx_base = rx_q.size(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_partial_frame();
    test_busy_handshake();
    test_enable_low();
    test_overflow();
    test_seq_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
